// File: rtl/uk101_pkg.sv
// Shared types and helpers for the UK101 serial receive arbiter.
// Holds the line-owner state encoding and the baud divisor helper.
package uk101_pkg;

   typedef enum logic [2:0] {
      S_UART,
      S_GUARD,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP
   } ser_state_t;

   localparam int DIV_W = 18;
   localparam logic [7:0] CR = 8'h0D;

   function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input int baud);
      return DIV_W'(clk_hz / baud);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Start-synchronised bit-period divider.
// restart zeroes the count; tick pulses for one cycle every div cycles.
module baud_tick_gen
   import uk101_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // >= keeps the divider sane if div shrinks while counting
   assign tick = (cnt >= div - DIV_W'(1));

   // count up within a bit period, wrap on tick, realign on restart
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/serial_rx_arbiter.sv
// Shares the ACIA receive line between the UART pin and OSD downloads.
// Download bytes are re-serialised as 8N1 frames at the selected baud.
module serial_rx_arbiter
   import uk101_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int BAUD_FAST   = 9600,
   parameter int BAUD_SLOW   = 300,
   parameter int GAP_BITS    = 2,
   parameter int CR_GAP_BITS = 200,
   parameter int GUARD_BITS  = 10
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       baud_rate,
   input  logic       uart_rxd,
   input  logic       acia_rts_n,
   input  logic       dl_active,
   input  logic       dl_wr,
   input  logic [7:0] dl_data,
   output logic       dl_ready,
   output logic       dl_overrun,
   output logic       rxd_out,
   output logic       dl_busy
);

   localparam logic [DIV_W-1:0] DIV_FAST = baud_div(CLK_HZ, BAUD_FAST);
   localparam logic [DIV_W-1:0] DIV_SLOW = baud_div(CLK_HZ, BAUD_SLOW);
   localparam logic [7:0] GAP_LAST    = 8'(GAP_BITS - 1);
   localparam logic [7:0] CR_GAP_LAST = 8'(CR_GAP_BITS - 1);
   localparam logic [7:0] GUARD_LAST  = 8'(GUARD_BITS - 1);

   ser_state_t       state;
   ser_state_t       state_d;
   logic             hold_full;
   logic [7:0]       hold_data;
   logic [7:0]       shift;
   logic             is_cr;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] live_div;
   logic [DIV_W-1:0] tick_div;
   logic [7:0]       bit_cnt;
   logic [7:0]       gap_last;
   logic             tick;
   logic             restart;
   logic             load;
   logic             line_d;

   assign live_div = baud_rate ? DIV_SLOW : DIV_FAST;
   // guard timing tracks the live selection; frames use the latched one
   assign tick_div = (state == S_GUARD) ? live_div : div_q;
   assign gap_last = is_cr ? CR_GAP_LAST : GAP_LAST;
   assign restart  = (state_d != state)
                   || (state == S_GUARD && !uart_rxd);
   assign load     = (state == S_IDLE) && (state_d == S_START);
   assign dl_ready = !hold_full;
   assign dl_busy  = (state != S_UART);

   baud_tick_gen u_tick (
      .clk     (clk_sys),
      .rst     (reset),
      .restart (restart),
      .div     (tick_div),
      .tick    (tick)
   );

   // line owner / framing next-state logic
   always_comb begin
      state_d = state;
      unique case (state)
         S_UART: begin
            if (dl_active || hold_full) state_d = S_GUARD;
         end
         S_GUARD: begin
            if (!dl_active && !hold_full) begin
               state_d = S_UART;
            end else if (uart_rxd && tick && bit_cnt == GUARD_LAST) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (hold_full && !acia_rts_n) begin
               state_d = S_START;
            end else if (!hold_full && !dl_active) begin
               state_d = S_UART;
            end
         end
         S_START: begin
            if (tick) state_d = S_DATA;
         end
         S_DATA: begin
            if (tick && bit_cnt == 8'd7) state_d = S_STOP;
         end
         S_STOP: begin
            if (tick) state_d = S_GAP;
         end
         S_GAP: begin
            if (tick && bit_cnt == gap_last) state_d = S_IDLE;
         end
         default: state_d = S_UART;
      endcase
   end

   // line level implied by the current owner state
   always_comb begin
      line_d = 1'b1;
      unique case (state)
         S_UART, S_GUARD: line_d = uart_rxd;
         S_START:         line_d = 1'b0;
         S_DATA:          line_d = shift[0];
         default:         line_d = 1'b1;
      endcase
   end

   // state register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= S_UART;
      else       state <= state_d;
   end

   // bit-period counter within the current state
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
      end else if (restart) begin
         bit_cnt <= '0;
      end else if (tick) begin
         bit_cnt <= bit_cnt + 8'd1;
      end
   end

   // holding register and sticky overrun flag
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hold_full  <= 1'b0;
         hold_data  <= '0;
         dl_overrun <= 1'b0;
      end else begin
         if (load) hold_full <= 1'b0;
         if (dl_wr) begin
            if (!hold_full) begin
               hold_full <= 1'b1;
               hold_data <= dl_data;
            end else begin
               dl_overrun <= 1'b1;
            end
         end
      end
   end

   // frame shifter plus per-frame baud and gap selection
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         shift <= '0;
         is_cr <= 1'b0;
         div_q <= DIV_FAST;
      end else if (load) begin
         shift <= hold_data;
         is_cr <= (hold_data == CR);
         div_q <= live_div;
      end else if (state == S_DATA && tick) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

   // registered line output, idle-high in reset
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) rxd_out <= 1'b1;
      else       rxd_out <= line_d;
   end

endmodule

// File: tb/tb_serial_rx_arbiter.sv
// Scoreboard bench for serial_rx_arbiter with scaled-down clock.
// A monitor decodes whole frames from rxd_out and checks them.
module tb_serial_rx_arbiter;

   localparam int CLK_HZ = 48000;
   localparam int DF     = CLK_HZ / 9600;
   localparam int DS     = CLK_HZ / 300;
   localparam int GUARD  = 10;

   typedef struct {
      logic [7:0] data;
      int         div;
      bit         b2b;
      bit         guard;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_rate;
   logic       uart_rxd;
   logic       acia_rts_n;
   logic       dl_active;
   logic       dl_wr;
   logic [7:0] dl_data;
   logic       dl_ready;
   logic       dl_overrun;
   logic       rxd_out;
   logic       dl_busy;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   exp_t cur;
   bit   mon_active = 1'b0;
   bit   mirror_en = 1'b0;
   logic rxd_prev = 1'b1;
   logic u_prev = 1'b1;
   logic [9:0] frame;
   int   cyc = 0;
   int   k = 0;
   int   ferr = 0;
   int   start_cyc = 0;
   int   last_start = 0;
   int   last_span = 0;
   int   last_low = 0;

   serial_rx_arbiter #(
      .CLK_HZ      (CLK_HZ),
      .BAUD_FAST   (9600),
      .BAUD_SLOW   (300),
      .GAP_BITS    (2),
      .CR_GAP_BITS (200),
      .GUARD_BITS  (GUARD)
   ) dut (
      .clk_sys    (clk),
      .reset      (rst),
      .baud_rate  (baud_rate),
      .uart_rxd   (uart_rxd),
      .acia_rts_n (acia_rts_n),
      .dl_active  (dl_active),
      .dl_wr      (dl_wr),
      .dl_data    (dl_data),
      .dl_ready   (dl_ready),
      .dl_overrun (dl_overrun),
      .rxd_out    (rxd_out),
      .dl_busy    (dl_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // monitor: mirror checks and cycle-exact 8N1 frame decode
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         mon_active = 1'b0;
         rxd_prev   = 1'b1;
         u_prev     = 1'b1;
      end else begin
         if (mirror_en) begin
            tests++;
            if (rxd_out !== u_prev) begin
               fails++;
               $display("FAIL mirror: rxd_out=%b want %b cyc %0d",
                        rxd_out, u_prev, cyc);
            end
         end
         if (!mon_active && rxd_prev && !rxd_out && u_prev) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_frame: start at cyc %0d want none", cyc);
            end else begin
               cur = exp_q.pop_front();
               mon_active = 1'b1;
               k = 0;
               ferr = 0;
               frame = {1'b1, cur.data, 1'b0};
               start_cyc = cyc;
               if (cur.b2b) begin
                  tests++;
                  if (cyc - last_start < last_span
                      || cyc - last_start > last_span + 2) begin
                     fails++;
                     $display("FAIL spacing: got %0d want %0d..%0d",
                              cyc - last_start, last_span, last_span + 2);
                  end
               end
               if (cur.guard) begin
                  tests++;
                  if (cyc - last_low < GUARD * cur.div) begin
                     fails++;
                     $display("FAIL guard: got %0d idle cycles want >= %0d",
                              cyc - last_low, GUARD * cur.div);
                  end
               end
            end
         end
         if (mon_active) begin
            if (rxd_out !== frame[k / cur.div]) ferr++;
            k++;
            if (k == 10 * cur.div) begin
               mon_active = 1'b0;
               tests++;
               if (ferr != 0) begin
                  fails++;
                  $display("FAIL frame %02h: %0d bad cycles want 0",
                           cur.data, ferr);
               end
               last_start = start_cyc;
               last_span  = (10 + (cur.data == 8'h0D ? 200 : 2)) * cur.div;
            end
         end
         if (!uart_rxd) last_low = cyc;
         rxd_prev = rxd_out;
         u_prev   = uart_rxd;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic push(input logic [7:0] d, input int dv,
                       input bit b2b, input bit g);
      exp_t e;
      e.data  = d;
      e.div   = dv;
      e.b2b   = b2b;
      e.guard = g;
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [7:0] d);
      dl_data = d;
      dl_wr   = 1'b1;
      step(1);
      dl_wr   = 1'b0;
   endtask

   task automatic wait_ready(input int lim);
      int n = 0;
      while (!dl_ready && n < lim) begin
         step(1);
         n++;
      end
      chk("ready_timeout", int'(dl_ready), 1);
   endtask

   task automatic wait_sent(input int lim);
      int n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         step(1);
         n++;
      end
      chk("sent_timeout", exp_q.size(), 0);
   endtask

   task automatic drain(input int lim, input int tail);
      int n = 0;
      while ((exp_q.size() != 0 || mon_active) && n < lim) begin
         step(1);
         n++;
      end
      chk("drain_timeout", exp_q.size() + int'(mon_active), 0);
      step(tail);
   endtask

   logic [9:0] ubits;

   initial begin
      rst = 1'b1;
      baud_rate = 1'b0;
      uart_rxd = 1'b1;
      acia_rts_n = 1'b0;
      dl_active = 1'b0;
      dl_wr = 1'b0;
      dl_data = '0;
      step(3);
      chk("reset_rxd", int'(rxd_out), 1);
      chk("reset_ready", int'(dl_ready), 1);
      chk("reset_overrun", int'(dl_overrun), 0);
      chk("reset_busy", int'(dl_busy), 0);
      rst = 1'b0;
      step(2);

      // UART passthrough
      mirror_en = 1'b1;
      repeat (40) begin
         uart_rxd = 1'($urandom_range(0, 1));
         step(1);
      end
      uart_rxd = 1'b1;
      step(2);
      mirror_en = 1'b0;
      chk("uart_busy", int'(dl_busy), 0);

      // download stream, back to back
      dl_active = 1'b1;
      push(8'h41, DF, 1'b0, 1'b1);
      wr(8'h41);
      for (int i = 0; i < 5; i++) begin
         logic [7:0] d;
         d = (i == 0) ? 8'h42 : 8'($urandom_range(0, 255));
         wait_ready(2000);
         push(d, DF, 1'b1, 1'b0);
         wr(d);
      end
      drain(5000, 1100);

      // uart_rxd ignored while download owns the line
      push(8'h6E, DF, 1'b0, 1'b0);
      wr(8'h6E);
      for (int n = 0; n < 50 && !mon_active; n++) step(1);
      repeat (6 * DF) begin
         uart_rxd = 1'($urandom_range(0, 1));
         step(1);
      end
      uart_rxd = 1'b1;
      drain(500, 20);

      // ACIA flow control
      acia_rts_n = 1'b1;
      wr(8'h99);
      for (int n = 0; n < 60; n++) begin
         step(1);
         chk("rts_hold_line", int'(rxd_out), 1);
      end
      chk("rts_hold_ready", int'(dl_ready), 0);
      push(8'h99, DF, 1'b0, 1'b0);
      acia_rts_n = 1'b0;
      step(1);
      chk("rts_rel_c1", int'(rxd_out), 1);
      step(1);
      chk("rts_rel_c2", int'(rxd_out), 0);
      step(3 * DF);
      acia_rts_n = 1'b1;
      wr(8'h3C);
      step(12 * DF + 10);
      chk("rts_mid_line", int'(rxd_out), 1);
      chk("rts_mid_ready", int'(dl_ready), 0);
      push(8'h3C, DF, 1'b0, 1'b0);
      acia_rts_n = 1'b0;
      drain(500, 20);

      // download requested during a live UART frame
      dl_active = 1'b0;
      step(2 * DF + 5);
      chk("back_to_uart", int'(dl_busy), 0);
      mirror_en = 1'b1;
      ubits = {1'b1, 8'hB2, 1'b0};
      for (int b = 0; b < 10; b++) begin
         uart_rxd = ubits[b];
         if (b == 3) begin
            dl_active = 1'b1;
            push(8'h5A, DF, 1'b0, 1'b1);
            wr(8'h5A);
            step(DF - 1);
         end else begin
            step(DF);
         end
      end
      uart_rxd = 1'b1;
      step(2);
      mirror_en = 1'b0;
      chk("guard_busy", int'(dl_busy), 1);
      drain(1000, 20);

      // slow baud, CR gap and overrun
      baud_rate = 1'b1;
      push(8'h0D, DS, 1'b0, 1'b0);
      wr(8'h0D);
      wait_ready(200);
      push(8'h31, DS, 1'b1, 1'b0);
      wr(8'h31);
      chk("overrun_pre", int'(dl_overrun), 0);
      wr(8'hEE);
      chk("overrun_set", int'(dl_overrun), 1);
      wait_sent(40000);
      baud_rate = 1'b0;
      drain(2000, 400);

      // reset in the middle of a data bit
      push(8'hA5, DF, 1'b0, 1'b0);
      wr(8'hA5);
      wait_ready(100);
      wr(8'h77);
      step(DF + 3);
      rst = 1'b1;
      #1;
      chk("rst_rxd", int'(rxd_out), 1);
      chk("rst_ready", int'(dl_ready), 1);
      chk("rst_busy", int'(dl_busy), 0);
      chk("rst_overrun", int'(dl_overrun), 0);
      exp_q.delete();
      dl_active = 1'b0;
      step(2);
      rst = 1'b0;
      step(3);
      chk("post_rst_busy", int'(dl_busy), 0);
      mirror_en = 1'b1;
      repeat (20) begin
         uart_rxd = 1'($urandom_range(0, 1));
         step(1);
      end
      uart_rxd = 1'b1;
      step(2);
      mirror_en = 1'b0;
      step(30 * DF);
      chk("post_rst_ready", int'(dl_ready), 1);
      chk("post_rst_idle", int'(dl_busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
